// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer for the data-memory port.
// One request in flight; alignment/funct3 checks, lanes, ack timeout.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_ILL = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        illegal;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Classify the incoming request: size, funct3 legality, alignment
  always_comb begin
    is_byte = (req_funct3[1:0] == 2'b00);
    is_half = (req_funct3[1:0] == 2'b01);
    is_word = (req_funct3[1:0] == 2'b10);
    if (req_we) begin
      illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
    end
    misaligned = (is_half & req_addr[0])
               | (is_word & (req_addr[1:0] != 2'b00));
  end

  // Replicate store data across lanes and build byte strobes
  always_comb begin
    st_wdata = req_wdata;
    st_wstrb = 4'b1111;
    unique case (1'b1)
      is_byte: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      is_half: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
    if (!req_we) begin
      st_wdata = 32'h0;
      st_wstrb = 4'b0000;
    end
  end

  // Pick the addressed lane of the raw word and extend it
  always_comb begin
    ld_b = mem_rdata[7:0];
    unique case (off_q)
      2'd0: ld_b = mem_rdata[7:0];
      2'd1: ld_b = mem_rdata[15:8];
      2'd2: ld_b = mem_rdata[23:16];
      2'd3: ld_b = mem_rdata[31:24];
      default: ld_b = mem_rdata[7:0];
    endcase
    ld_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'h0, ld_b};
      3'b101:  ld_data = {16'h0, ld_h};
      default: ld_data = mem_rdata;
    endcase
  end

  // Sequencer: accept, access with timeout, one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'h0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'b0000;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= req_funct3;
            off_q    <= req_addr[1:0];
            if (illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_ILL;
              resp_rdata <= 32'h0;
            end else if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= ERR_MIS;
              resp_rdata <= 32'h0;
            end else begin
              state     <= ACCESS;
              cnt       <= 8'h0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= st_wdata;
              mem_wstrb <= st_wstrb;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_rdata <= mem_we ? 32'h0 : ld_data;
          end else if (cnt == CNT_LAST) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= ERR_TO;
            resp_rdata <= 32'h0;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vector table plus reset and timeout sequences.
// A second instance with TIMEOUT=4 covers the timeout boundary.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid4 = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        mem_ack4 = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        a_ready, a_mreq, a_mwe, a_rv, a_busy;
  logic [31:0] a_maddr, a_mwdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic [1:0]  a_err;
  logic        b_ready, b_mreq, b_mwe, b_rv, b_busy;
  logic [31:0] b_maddr, b_mwdata, b_rdata;
  logic [3:0]  b_wstrb;
  logic [1:0]  b_err;

  bit          sel = 1'b0;
  logic        o_ready, o_mreq, o_mwe, o_rv, o_busy;
  logic [31:0] o_maddr, o_mwdata, o_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(a_mreq), .mem_we(a_mwe),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_wstrb(a_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .resp_valid(a_rv),
    .resp_rdata(a_rdata), .resp_err(a_err),
    .busy(a_busy)
  );

  lsu_ctrl #(.TIMEOUT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid4), .req_ready(b_ready),
    .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(b_mreq), .mem_we(b_mwe),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_wstrb(b_wstrb), .mem_ack(mem_ack4),
    .mem_rdata(mem_rdata), .resp_valid(b_rv),
    .resp_rdata(b_rdata), .resp_err(b_err),
    .busy(b_busy)
  );

  assign o_ready  = sel ? b_ready  : a_ready;
  assign o_mreq   = sel ? b_mreq   : a_mreq;
  assign o_mwe    = sel ? b_mwe    : a_mwe;
  assign o_rv     = sel ? b_rv     : a_rv;
  assign o_busy   = sel ? b_busy   : a_busy;
  assign o_maddr  = sel ? b_maddr  : a_maddr;
  assign o_mwdata = sel ? b_mwdata : a_mwdata;
  assign o_rdata  = sel ? b_rdata  : a_rdata;
  assign o_wstrb  = sel ? b_wstrb  : a_wstrb;
  assign o_err    = sel ? b_err    : a_err;

  typedef struct {
    string       name;
    bit          dut4;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
    int          e_reqc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  reqc;
    int  respc;
    bit  done;
    bit  bad_busy;
    bit  bad_mem;
    @(negedge clk);
    sel = v.dut4;
    #1;
    chk({v.name, " ready"}, 32'(o_ready), 32'h1);
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_rdata  = v.rdata;
    if (v.dut4) req_valid4 = 1'b1;
    else req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
    reqc = 0;
    respc = 0;
    done = 1'b0;
    bad_busy = 1'b0;
    bad_mem = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (!o_busy || o_ready) bad_busy = 1'b1;
      if (o_mreq) begin
        reqc++;
        if (o_maddr !== v.e_maddr || o_mwe !== v.we
            || o_wstrb !== v.e_wstrb) bad_mem = 1'b1;
        if (v.we && o_mwdata !== v.e_wdata) bad_mem = 1'b1;
      end
      if (o_rv) begin
        respc = c;
        done = 1'b1;
        chk({v.name, " rdata"}, o_rdata, v.e_rdata);
        chk({v.name, " err"}, 32'(o_err), 32'(v.e_err));
      end
      if (o_mreq && v.dly >= 0 && reqc == v.dly + 1) begin
        if (v.dut4) mem_ack4 = 1'b1;
        else mem_ack = 1'b1;
      end else begin
        mem_ack  = 1'b0;
        mem_ack4 = 1'b0;
      end
    end
    mem_ack  = 1'b0;
    mem_ack4 = 1'b0;
    chk({v.name, " mem_req cycles"}, 32'(reqc), 32'(v.e_reqc));
    chk({v.name, " resp cycle"}, 32'(respc), 32'(v.e_reqc + 1));
    chk({v.name, " busy/ready"}, 32'(bad_busy), 32'h0);
    chk({v.name, " mem outputs"}, 32'(bad_mem), 32'h0);
  endtask

  function automatic vec_t mk(
    input string nm, input bit d4, input logic we, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rdata, input int dly, input logic [31:0] e_wdata,
    input logic [3:0] e_wstrb, input logic [31:0] e_rdata,
    input logic [1:0] e_err, input int e_reqc);
    vec_t v;
    v.name = nm; v.dut4 = d4; v.we = we; v.f3 = f3;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
    v.e_maddr = {addr[31:2], 2'b00};
    v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
    v.e_rdata = e_rdata; v.e_err = e_err; v.e_reqc = e_reqc;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk("lb", 0, 0, 3'b000, 32'h1003, 0,
      32'h80112233, 0, 0, 4'b0000, 32'hFFFFFF80, 2'b00, 1));
    vecs.push_back(mk("lbu", 0, 0, 3'b100, 32'h1003, 0,
      32'h80112233, 0, 0, 4'b0000, 32'h00000080, 2'b00, 1));
    vecs.push_back(mk("sh", 0, 1, 3'b001, 32'h2002, 32'h0000BEEF,
      32'h0, 0, 32'hBEEFBEEF, 4'b1100, 32'h0, 2'b00, 1));
    vecs.push_back(mk("lw_mis", 0, 0, 3'b010, 32'h3001, 0,
      32'h0, -1, 0, 4'b0000, 32'h0, 2'b01, 0));
    vecs.push_back(mk("ld_ill", 0, 0, 3'b011, 32'h3001, 0,
      32'h0, -1, 0, 4'b0000, 32'h0, 2'b10, 0));
    vecs.push_back(mk("lhu_wait5", 0, 0, 3'b101, 32'h4002, 0,
      32'hA5A51234, 5, 0, 4'b0000, 32'h0000A5A5, 2'b00, 6));
    vecs.push_back(mk("sb", 0, 1, 3'b000, 32'h5001, 32'h123456AB,
      32'h0, 0, 32'hABABABAB, 4'b0010, 32'h0, 2'b00, 1));
    vecs.push_back(mk("sw_wait2", 0, 1, 3'b010, 32'h6000, 32'hDEADBEEF,
      32'h0, 2, 32'hDEADBEEF, 4'b1111, 32'h0, 2'b00, 3));
    vecs.push_back(mk("lh", 0, 0, 3'b001, 32'h7000, 0,
      32'h12348001, 0, 0, 4'b0000, 32'hFFFF8001, 2'b00, 1));
    vecs.push_back(mk("st_ill", 0, 1, 3'b100, 32'h7000, 32'h1,
      32'h0, -1, 0, 4'b0000, 32'h0, 2'b10, 0));
    vecs.push_back(mk("sh_mis", 0, 1, 3'b001, 32'h2001, 32'h1,
      32'h0, -1, 0, 4'b0000, 32'h0, 2'b01, 0));
    vecs.push_back(mk("lw_wait1", 0, 0, 3'b010, 32'h8004, 0,
      32'hCAFEF00D, 1, 0, 4'b0000, 32'hCAFEF00D, 2'b00, 2));
    vecs.push_back(mk("lb_pos", 0, 0, 3'b000, 32'h0010, 0,
      32'h0000007F, 0, 0, 4'b0000, 32'h0000007F, 2'b00, 1));
    vecs.push_back(mk("to4_noack", 1, 0, 3'b010, 32'h9000, 0,
      32'h11223344, -1, 0, 4'b0000, 32'h0, 2'b11, 4));
    vecs.push_back(mk("to4_ack4th", 1, 0, 3'b010, 32'h9000, 0,
      32'h11223344, 3, 0, 4'b0000, 32'h11223344, 2'b00, 4));

    #3;
    chk("rst req_ready", 32'(a_ready), 32'h1);
    chk("rst busy", 32'(a_busy), 32'h0);
    chk("rst mem_req", 32'(a_mreq), 32'h0);
    chk("rst mem_we", 32'(a_mwe), 32'h0);
    chk("rst resp_valid", 32'(a_rv), 32'h0);
    chk("rst mem_addr", a_maddr, 32'h0);
    chk("rst mem_wdata", a_mwdata, 32'h0);
    chk("rst mem_wstrb", 32'(a_wstrb), 32'h0);
    chk("rst resp_rdata", a_rdata, 32'h0);
    chk("rst resp_err", 32'(a_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset pulse in the middle of an access
    @(negedge clk);
    sel = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h4000;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid mem_req before rst", 32'(a_mreq), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst mem_req", 32'(a_mreq), 32'h0);
    chk("mid rst resp_valid", 32'(a_rv), 32'h0);
    chk("mid rst ready", 32'(a_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (a_rv || a_mreq || a_busy) seen = 1'b1;
      end
      chk("post rst quiet", 32'(seen), 32'h0);
    end
    run_vec(mk("lw_after_rst", 0, 0, 3'b010, 32'h0, 0,
      32'h55AA55AA, 0, 0, 4'b0000, 32'h55AA55AA, 2'b00, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
